bcd_disp_scan: RTL and testbench
================================

BCD_DISP_SCAN -- requirements
Module: bcd_disp_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 50000, meaning the clock cycles each digit is lit (1 ms at 50 MHz).
REQ-002 The module SHALL have parameter GAP_CYC, default 16, meaning the clock cycles all anodes are off between digits (anti-ghosting).
REQ-003 The module SHALL have port clk, input, 1 bit, the single system clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port bcd, input, 20 bits: [19:16] sign nibble (4'd5 = negative, anything else = non-negative), [15:0] four BCD magnitude digits, thousands first.
REQ-006 The module SHALL have port load, input, 1 bit, a one-cycle strobe marking bcd valid for capture.
REQ-007 The module SHALL have port blank_lz, input, 1 bit, the leading-zero blanking enable.
REQ-008 The module SHALL have port ack, output, 1 bit, a one-cycle pulse when captured data becomes the displayed value.
REQ-009 The module SHALL have port an, output, 5 bits, active-low digit enables: an[4] sign position, an[0] units.
REQ-010 The module SHALL have port seg, output, 7 bits, active-low segments {g,f,e,d,c,b,a}.

Function
REQ-011 The FSM SHALL have two states: ON (digit idx lit) and GAP (an = 5'b11111, seg = 7'h7F).
REQ-012 ON SHALL last exactly SCAN_DIV cycles, then go to GAP; GAP SHALL last exactly GAP_CYC cycles, then go to ON with idx advanced.
REQ-013 idx SHALL advance 0,1,2,3,4 and wrap 4 to 0; the last GAP cycle before the wrap is the frame boundary.
REQ-014 an and seg SHALL be registered and SHALL change on the same edge the FSM enters a state; in ON, an = ~(1<<idx).
REQ-015 On load=1, bcd SHALL be copied into a staging register and a pending flag set on that edge.
REQ-016 At the frame boundary with pending=1, staging SHALL copy to the shadow register, pending SHALL clear, and ack SHALL be 1 for exactly that cycle.
REQ-017 Repeated loads while pending SHALL overwrite staging; only one ack is issued, for the last value.
REQ-018 A load coinciding with the frame boundary SHALL transfer the previous staging value (if pending), write the new value to staging, and leave pending set for the next boundary.
REQ-019 The displayed digits SHALL come only from shadow; bcd changes without load SHALL have no effect.
REQ-020 Decode SHALL be: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; digit >9 SHALL show E=7'h06.
REQ-021 Sign position SHALL show minus (7'h3F) when the shadow sign nibble = 4'd5, else blank (7'h7F).
REQ-022 With blank_lz=1, digits 3..1 SHALL show 7'h7F when they and every more significant magnitude digit are 4'd0; digit 0 is never blanked.
REQ-023 blank_lz SHALL be sampled live and take effect on the next ON entry.

Reset
REQ-024 On rst_n low: state GAP, idx 0, counters 0, shadow and staging 20'h0, pending 0, ack 0, an 5'b11111, seg 7'h7F.
REQ-025 After rst_n deasserts, the first ON SHALL be idx 0, entered after GAP_CYC cycles.
REQ-026 Reset mid-frame SHALL discard pending data with no ack.

Structure
REQ-027 Package bcd_disp_pkg SHALL hold the state enum, NDIG=5, the SIGN_NEG=4'd5 constant and segment constants (digits, MINUS, BLANK, ERR).
REQ-028 A combinational sub-module seg7_dec (4-bit digit plus blank flag in, 7-bit active-low segments out) SHALL be instantiated once on the selected digit.
REQ-029 Counter widths SHALL be $clog2 of the larger of SCAN_DIV and GAP_CYC, with a minimum of 1.

Verification (SCAN_DIV=4, GAP_CYC=2)
REQ-030 Reset, then no load -> an cycles 11110,11101,11011,10111,01111 with 2-cycle 11111 gaps; seg shows 7'h40 on idx 0..3 and 7'h7F on idx 4; frame is 30 cycles.
REQ-031 Load bcd=20'h51234 mid-frame -> ack at next boundary only; next frame shows 7'h19,7'h30,7'h24,7'h79 on idx 0..3 and 7'h3F on idx 4.
REQ-032 Load 20'h00007 with blank_lz=1 -> idx 3..1 show 7'h7F, idx 0 shows 7'h78, idx 4 blank; with blank_lz=0 -> idx 3..1 show 7'h40.
REQ-033 Three loads (20'h00001, 20'h00002, 20'h00003) within one frame -> single ack; displayed units digit is 7'h30.
REQ-034 Load exactly on the boundary cycle while pending holds 20'h00009 -> 9 is displayed with ack; new value displayed with a second ack one frame later.
REQ-035 Load 20'h0A000, then assert rst_n low mid-frame while pending -> no ack, all-zero display resumes; a separate load of 20'h0A000 -> idx 3 shows 7'h06.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared state type, digit count, sign code and 7-segment constants.
package bcd_disp_pkg;
  typedef enum logic {ST_GAP, ST_ON} state_t;
  localparam int NDIG = 5;
  localparam logic [3:0] SIGN_NEG = 4'd5;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ERR = 7'h06;
  localparam logic [0:15][6:0] SEG_TAB = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR
  };
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: BCD nibble to active-low {g..a} segments; i_blank forces all off, >9 shows E.
module seg7_dec
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_dig,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  assign o_seg = i_blank ? SEG_BLANK : SEG_TAB[i_dig];
endmodule

// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan: 5-position multiplexed 7-seg scanner (sign + 4 BCD digits) with frame-synchronous load/ack.
module bcd_disp_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] bcd,
  input  logic        load,
  input  logic        blank_lz,
  output logic        ack,
  output logic [4:0]  an,
  output logic [6:0]  seg
);
  localparam int CMAX = SCAN_DIV > GAP_CYC ? SCAN_DIV : GAP_CYC;
  localparam int CW = $clog2(CMAX) < 1 ? 1 : $clog2(CMAX);
  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [19:0] r_shadow, r_stage, w_shadow_nxt;
  logic        r_pend, r_ack;
  logic [4:0]  r_an;
  logic [6:0]  r_seg, w_dec, w_seg;
  logic [3:0]  w_dig;
  logic        w_bnd, w_lz, w_enter;
  // r_idx points at the digit of the current ON or the one the pending GAP leads into,
  // so the gap ahead of idx 0 is the frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    if (r_state == ST_ON && r_cnt == CW'(SCAN_DIV - 1)) begin
      w_state_nxt = ST_GAP;
      w_cnt_nxt   = '0;
      w_idx_nxt   = r_idx == 3'(NDIG - 1) ? 3'd0 : r_idx + 3'd1;
    end else if (r_state == ST_GAP && r_cnt == CW'(GAP_CYC - 1)) begin
      w_state_nxt = ST_ON;
      w_cnt_nxt   = '0;
    end
  end
  assign w_bnd        = r_state == ST_GAP && r_cnt == CW'(GAP_CYC - 1) && r_idx == 3'd0;
  assign w_shadow_nxt = (w_bnd && r_pend) ? r_stage : r_shadow;
  assign w_enter      = w_state_nxt != r_state;
  // Decode from the post-edge shadow so a boundary transfer shows on the very first idx 0.
  assign w_dig = w_shadow_nxt[{w_idx_nxt[1:0], 2'b00} +: 4];
  assign w_lz  = w_idx_nxt == 3'd3 ? w_shadow_nxt[15:12] == 4'd0 :
                 w_idx_nxt == 3'd2 ? w_shadow_nxt[15:8]  == 8'd0 :
                 w_idx_nxt == 3'd1 ? w_shadow_nxt[15:4]  == 12'd0 : 1'b0;
  seg7_dec u_dec (.i_dig(w_dig), .i_blank(blank_lz && w_lz), .o_seg(w_dec));
  assign w_seg = w_idx_nxt == 3'(NDIG - 1) ?
                 (w_shadow_nxt[19:16] == SIGN_NEG ? SEG_MINUS : SEG_BLANK) : w_dec;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_GAP;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 20'h0;
      r_stage  <= 20'h0;
      r_pend   <= 1'b0;
      r_ack    <= 1'b0;
      r_an     <= 5'h1F;
      r_seg    <= SEG_BLANK;
    end else begin
      r_shadow <= w_shadow_nxt;
      r_stage  <= load ? bcd : r_stage;
      r_pend   <= load | (r_pend & ~w_bnd);
      r_ack    <= w_bnd & r_pend;
      // Outputs only move on state entry so a live blank_lz change waits for the next ON.
      r_an     <= !w_enter ? r_an : w_state_nxt == ST_ON ? ~(5'b1 << w_idx_nxt) : 5'h1F;
      r_seg    <= !w_enter ? r_seg : w_state_nxt == ST_ON ? w_seg : SEG_BLANK;
    end
  end
  assign ack = r_ack;
  assign an  = r_an;
  assign seg = r_seg;
endmodule

// File: tb/tb_bcd_disp_scan.sv
// tb_bcd_disp_scan: directed frame-by-frame checks of the scanner with SCAN_DIV=4, GAP_CYC=2.
module tb_bcd_disp_scan;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] bcd;
  logic        load;
  logic        blank_lz;
  logic        ack;
  logic [4:0]  an;
  logic [6:0]  seg;
  int n_chk = 0;
  int n_err = 0;
  int fr = 0;
  bcd_disp_scan #(.SCAN_DIV(4), .GAP_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .blank_lz(blank_lz),
    .ack(ack), .an(an), .seg(seg)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    @(posedge clk); #1;
    check("rst an", 32'(an), 32'h1F);
    check("rst seg", 32'(seg), 32'h7F);
    check("rst ack", 32'(ack), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst gap an", 32'(an), 32'h1F);
    check("rst gap ack", 32'(ack), 32'h0);
    @(posedge clk); #1;
  endtask
  // Entered one step after the edge that starts idx 0; leaves at the same point of the next frame.
  // segs packs expected segments {idx4,idx3,idx2,idx1,idx0}; offsets < 0 mean no load.
  task automatic run_frame(input logic [34:0] segs, input logic ack_e,
                           input int l0, input logic [19:0] v0,
                           input int l1, input logic [19:0] v1,
                           input int l2, input logic [19:0] v2);
    int i;
    logic on;
    logic [4:0] ea;
    logic [6:0] es;
    for (int t = 0; t < 30; t++) begin
      i  = t / 6;
      on = (t % 6) < 4;
      ea = on ? ~(5'b1 << i) : 5'h1F;
      es = on ? segs[7*i +: 7] : 7'h7F;
      check($sformatf("an f%0d t%0d", fr, t), 32'(an), 32'(ea));
      check($sformatf("seg f%0d t%0d", fr, t), 32'(seg), 32'(es));
      check($sformatf("ack f%0d t%0d", fr, t), 32'(ack), 32'(t == 0 ? ack_e : 1'b0));
      load = 1'b1;
      if (t == l0) bcd = v0;
      else if (t == l1) bcd = v1;
      else if (t == l2) bcd = v2;
      else begin
        load = 1'b0;
        bcd  = 20'h59999;
      end
      @(posedge clk); #1;
    end
    load = 1'b0;
    fr++;
  endtask
  initial begin
    bcd = 20'h0;
    blank_lz = 1'b0;
    do_reset();
    run_frame({7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 10, 20'h51234, -1, 0, -1, 0);
    run_frame({7'h3F, 7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, 10, 20'h00007, -1, 0, -1, 0);
    run_frame({7'h7F, 7'h40, 7'h40, 7'h40, 7'h78}, 1'b1, -1, 0, -1, 0, -1, 0);
    blank_lz = 1'b1;
    run_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0, 3, 20'h00001, 9, 20'h00002, 15, 20'h00003);
    run_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30}, 1'b1, 5, 20'h00009, 29, 20'h00006, -1, 0);
    run_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10}, 1'b1, -1, 0, -1, 0, -1, 0);
    blank_lz = 1'b0;
    run_frame({7'h7F, 7'h40, 7'h40, 7'h40, 7'h02}, 1'b1, -1, 0, -1, 0, -1, 0);
    for (int t = 0; t < 10; t++) begin
      load = (t == 3);
      bcd  = 20'h0A000;
      @(posedge clk); #1;
      check($sformatf("pre-rst ack t%0d", t), 32'(ack), 32'h0);
    end
    do_reset();
    run_frame({7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, -1, 0, -1, 0, -1, 0);
    run_frame({7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 10, 20'h0A000, -1, 0, -1, 0);
    run_frame({7'h7F, 7'h06, 7'h40, 7'h40, 7'h40}, 1'b1, -1, 0, -1, 0, -1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
